// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared states, digit limits and BCD increment for the stopwatch core
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int DIGITS_W = 16;

  localparam logic [3:0] HUND_MAX  = 4'd9;
  localparam logic [3:0] TENTH_MAX = 4'd9;
  localparam logic [3:0] SEC_U_MAX = 4'd9;
  localparam logic [3:0] SEC_T_MAX = 4'd5;

  // Returns {wrap, next_digits}; a digit at or above its limit folds to 0 and carries.
  function automatic logic [DIGITS_W:0] bcd_inc(input logic [DIGITS_W-1:0] d);
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] su;
    logic [3:0] st;
    logic       wrap;
    h    = d[3:0];
    t    = d[7:4];
    su   = d[11:8];
    st   = d[15:12];
    wrap = 1'b0;
    if (h >= HUND_MAX) begin
      h = 4'd0;
      if (t >= TENTH_MAX) begin
        t = 4'd0;
        if (su >= SEC_U_MAX) begin
          su = 4'd0;
          if (st >= SEC_T_MAX) begin
            st   = 4'd0;
            wrap = 1'b1;
          end else begin
            st = st + 4'd1;
          end
        end else begin
          su = su + 4'd1;
        end
      end else begin
        t = t + 4'd1;
      end
    end else begin
      h = h + 4'd1;
    end
    return {wrap, st, su, t, h};
  endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop button synchroniser with rising-edge detect
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic edge_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;
  logic vld1_q, vld1_d;
  logic vld2_q, vld2_d;
  logic arm_q, arm_d;

  // Edges stay disarmed until sync2 has held a genuine low sample, so a button
  // held through reset must be released and pressed again.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    vld1_d  = 1'b1;
    vld2_d  = vld1_q;
    arm_d   = arm_q | (vld2_q & ~sync2_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      arm_q   <= arm_d;
    end
  end

  assign edge_pulse = sync2_q & ~dly_q & arm_q;

endmodule

// File: rtl/stopwatch_bcd_core.sv
// rtl/stopwatch_bcd_core.sv - run/pause FSM, 0.01 s prescaler and 00.00-59.99 BCD counter
module stopwatch_bcd_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_startstop,
  input  logic                btn_clear,
  output logic [DIGITS_W-1:0] digits,
  output logic                running,
  output logic                rollover
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic ss_edge;
  logic clr_edge;

  sync_edge u_ss_sync (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_startstop),
    .edge_pulse(ss_edge)
  );

  sync_edge u_clr_sync (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_clear),
    .edge_pulse(clr_edge)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    presc_q, presc_d;
  logic [DIGITS_W-1:0] digits_q, digits_d;
  logic                running_q, running_d;
  logic                rollover_q, rollover_d;
  logic                tick;
  logic [DIGITS_W:0]   inc;

  assign inc = bcd_inc(digits_q);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    digits_d   = digits_q;
    rollover_d = 1'b0;
    tick       = 1'b0;
    if (clr_edge) begin
      state_d  = IDLE;
      presc_d  = '0;
      digits_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_edge) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (presc_q == CNT_W'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick    = 1'b1;
          end else begin
            presc_d = presc_q + CNT_W'(1);
          end
          if (tick) begin
            digits_d   = inc[DIGITS_W-1:0];
            rollover_d = inc[DIGITS_W];
          end
          if (ss_edge) state_d = PAUSE;
        end
        PAUSE: begin
          if (ss_edge) state_d = RUN;
        end
        default: begin
          state_d  = IDLE;
          presc_d  = '0;
          digits_d = '0;
        end
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      digits_q   <= '0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      digits_q   <= digits_d;
      running_q  <= running_d;
      rollover_q <= rollover_d;
    end
  end

  assign digits   = digits_q;
  assign running  = running_q;
  assign rollover = rollover_q;

endmodule
